// File: rtl/tpu_arb_pkg.sv
// Shared types and job-size constants for the MMU job arbiter.
// The arbiter shares one 2x2 systolic core between several host requesters.
package tpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int BEATS_IN  = 8;
    localparam int BEATS_OUT = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after
// ptr, wrapping around, plus a flag telling whether any request is set.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_W-1:0]   ptr,
    output logic [REQ_W-1:0]   grant,
    output logic               any
);

    int idx;

    // Walk from the farthest offset back to ptr so the closest request wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (req[idx]) begin
                grant = REQ_W'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmu_job_arbiter.sv
// Round-robin job arbiter in front of the shared 2x2 systolic MMU core.
// Define ARB_TIMEOUT_EN to enable the LOAD/WAIT stall timeout with abort pulse.
module mmu_job_arbiter
    import tpu_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int REQ_W          = $clog2(NUM_REQ),
    parameter int BEATS_IN       = tpu_arb_pkg::BEATS_IN,
    parameter int BEATS_OUT      = tpu_arb_pkg::BEATS_OUT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_transpose,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 core_load_en,
    output logic [7:0]           core_data,
    output logic                 core_transpose,
    input  logic                 core_done,
    input  logic [7:0]           core_outdata,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [7:0]           resp_data,
    output logic                 busy,
    output logic [REQ_W-1:0]     owner,
    output logic                 abort
);

    localparam int IN_W  = $clog2(BEATS_IN);
    localparam int OUT_W = $clog2(BEATS_OUT);

    state_t           state;
    logic [REQ_W-1:0] rr_ptr;
    logic [IN_W-1:0]  in_cnt;
    logic [OUT_W-1:0] out_cnt;

    logic [REQ_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_valid;
    logic [7:0]       owner_byte;
    logic             load_beat;
    logic             resp_beat;
    logic [REQ_W-1:0] next_ptr;
    logic             stall_hit;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .REQ_W  (REQ_W)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(pick_idx),
        .any  (pick_any)
    );

    assign owner_valid = req_valid[owner];
    assign owner_byte  = req_data[8*owner +: 8];
    assign load_beat   = (state == LOAD) && owner_valid;
    assign resp_beat   = ((state == WAIT) || (state == DRAIN)) && core_done;
    assign next_ptr    = (owner == REQ_W'(NUM_REQ - 1)) ? '0 : owner + REQ_W'(1);

    assign req_ready    = (state == LOAD) ? (NUM_REQ'(1) << owner) : '0;
    assign core_load_en = load_beat;
    assign core_data    = (state == LOAD) ? owner_byte : 8'h00;
    assign resp_valid   = resp_beat ? (NUM_REQ'(1) << owner) : '0;
    assign resp_data    = resp_beat ? core_outdata : 8'h00;
    assign busy         = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stalling;

    // A stall is a LOAD cycle with no accepted beat or a WAIT cycle without core_done.
    assign stalling  = ((state == LOAD) && !owner_valid) || ((state == WAIT) && !core_done);
    assign stall_hit = stalling && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            abort     <= 1'b0;
        end else begin
            abort     <= stall_hit;
            stall_cnt <= (stalling && !stall_hit) ? stall_cnt + STALL_W'(1) : '0;
        end
    end
`else
    // Keeps the timeout parameter referenced when the feature is compiled out.
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign stall_hit = 1'b0;
    assign abort     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            in_cnt         <= '0;
            out_cnt        <= '0;
            core_transpose <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner          <= pick_idx;
                        core_transpose <= req_transpose[pick_idx];
                        in_cnt         <= '0;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_beat) begin
                        if (in_cnt == IN_W'(BEATS_IN - 1)) begin
                            in_cnt <= '0;
                            state  <= WAIT;
                        end else begin
                            in_cnt <= in_cnt + IN_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        out_cnt <= OUT_W'(1);
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (core_done) begin
                        if (out_cnt == OUT_W'(BEATS_OUT - 1)) begin
                            out_cnt <= '0;
                            rr_ptr  <= next_ptr;
                            state   <= IDLE;
                        end else begin
                            out_cnt <= out_cnt + OUT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A timed-out job is dropped and the turn passes to the next requester.
            if (stall_hit) begin
                state   <= IDLE;
                rr_ptr  <= next_ptr;
                in_cnt  <= '0;
                out_cnt <= '0;
            end
        end
    end

endmodule
